// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// Signal suffixes are from the arbiter's point of view.
interface mem_arbiter_if #(
    parameter int ADDR_SIZE = 10
);
    logic                 i_re_i;
    logic [ADDR_SIZE-1:0] i_add_i;
    logic [31:0]          i_d_o;
    logic                 i_valid_o;

    logic                 d_re_i;
    logic                 d_we_i;
    logic [3:0]           d_ble_i;
    logic [ADDR_SIZE-1:0] d_add_i;
    logic [31:0]          d_d_i;
    logic [31:0]          d_d_o;
    logic                 d_valid_o;

    logic                 mem_re_o;
    logic                 mem_we_o;
    logic [3:0]           mem_ble_o;
    logic [ADDR_SIZE-1:0] mem_add_o;
    logic [31:0]          mem_d_o;
    logic [31:0]          mem_d_i;
    logic                 mem_valid_i;

    logic [1:0]           grant_o;

    // Arbiter side
    modport slave (
        input  i_re_i, i_add_i,
        output i_d_o, i_valid_o,
        input  d_re_i, d_we_i, d_ble_i, d_add_i, d_d_i,
        output d_d_o, d_valid_o,
        output mem_re_o, mem_we_o, mem_ble_o, mem_add_o, mem_d_o,
        input  mem_d_i, mem_valid_i,
        output grant_o
    );

    // Requesters plus memory side
    modport master (
        output i_re_i, i_add_i,
        input  i_d_o, i_valid_o,
        output d_re_i, d_we_i, d_ble_i, d_add_i, d_d_i,
        input  d_d_o, d_valid_o,
        input  mem_re_o, mem_we_o, mem_ble_o, mem_add_o, mem_d_o,
        output mem_d_i, mem_valid_i,
        input  grant_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of one shared single-port memory.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise data wins ties.
module mem_arbiter #(
    parameter int ADDR_SIZE = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic i_req;
    logic d_req;
    logic d_rd;
    logic done;
    logic tie_i_wins;

    logic [ADDR_SIZE-1:0] add_sel;

    assign i_req = bus.i_re_i;
    assign d_req = bus.d_re_i | bus.d_we_i;
    // A write strobe overrides a simultaneous read strobe
    assign d_rd  = bus.d_re_i & ~bus.d_we_i;
    assign done  = bus.mem_valid_i;

    function automatic state_t pick(
        input logic ir,
        input logic dr,
        input logic ti
    );
        state_t s;
        s = IDLE;
        if (ir && dr) begin
            s = ti ? GNT_I : GNT_D;
        end else if (ir) begin
            s = GNT_I;
        end else if (dr) begin
            s = GNT_D;
        end
        return s;
    endfunction

`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    logic last_d_d;

    assign tie_i_wins = last_d_q;

    // Remember which port completed last; the other one wins the next tie
    always_comb begin
        last_d_d = last_d_q;
        if (done && state_q == GNT_I) begin
            last_d_d = 1'b0;
        end else if (done && state_q == GNT_D) begin
            last_d_d = 1'b1;
        end
    end

    // Last-served pointer; reset so the instruction port wins first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign tie_i_wins = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: hold the owner until its completion, then hand over
    // to the other port if it is waiting; the finishing port must
    // re-arbitrate later even if its request is still high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = pick(i_req, d_req, tie_i_wins);
            end
            GNT_I: begin
                if (done) begin
                    state_d = d_req ? GNT_D : IDLE;
                end else if (!i_req) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (done) begin
                    state_d = i_req ? GNT_I : IDLE;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_add_o = add_sel;

    // Memory request and port returns, decoded from the owner
    always_comb begin
        bus.mem_re_o  = 1'b0;
        bus.mem_we_o  = 1'b0;
        bus.mem_ble_o = 4'b0000;
        bus.mem_d_o   = 32'h0;
        add_sel       = '0;
        bus.grant_o   = 2'b00;
        bus.i_valid_o = 1'b0;
        bus.i_d_o     = 32'h0;
        bus.d_valid_o = 1'b0;
        bus.d_d_o     = 32'h0;
        unique case (state_q)
            GNT_I: begin
                bus.mem_re_o  = 1'b1;
                bus.mem_ble_o = 4'b1111;
                add_sel       = bus.i_add_i;
                bus.grant_o   = 2'b01;
                bus.i_valid_o = done;
                bus.i_d_o     = bus.mem_d_i;
            end
            GNT_D: begin
                bus.mem_re_o  = d_rd;
                bus.mem_we_o  = bus.d_we_i;
                bus.mem_ble_o = bus.d_ble_i;
                bus.mem_d_o   = bus.d_d_i;
                add_sel       = bus.d_add_i;
                bus.grant_o   = 2'b10;
                bus.d_valid_o = done;
                if (d_rd) begin
                    bus.d_d_o = bus.mem_d_i;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus a random
// two-requester run scored against a shadow memory and arbitration rules.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   ws;
    int   mcnt;

    logic [31:0] mem [1024];
    logic [31:0] shadow [1024];

    mem_arbiter_if #(.ADDR_SIZE(10)) bus ();

    mem_arbiter #(.ADDR_SIZE(10)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory with ws wait states, async read, lane write on completion
    logic strobe;
    assign strobe          = bus.mem_re_o | bus.mem_we_o;
    assign bus.mem_valid_i = strobe && (mcnt == ws);
    assign bus.mem_d_i     = mem[bus.mem_add_o];

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
            for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
        end else begin
            if (!strobe || bus.mem_valid_i) mcnt <= 0;
            else mcnt <= mcnt + 1;
            if (bus.mem_valid_i && bus.mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_ble_o[b])
                        mem[bus.mem_add_o][8*b +: 8] <= bus.mem_d_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.i_re_i  = 1'b0;
        bus.i_add_i = '0;
        bus.d_re_i  = 1'b0;
        bus.d_we_i  = 1'b0;
        bus.d_ble_i = 4'h0;
        bus.d_add_i = '0;
        bus.d_d_i   = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One data-port access; returns read data, bounded wait for valid
    task automatic d_access(input string tag, input logic re, input logic we,
                            input logic [3:0] ble, input logic [9:0] a,
                            input logic [31:0] wd, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd = 32'h0;
        bus.d_re_i  = re;
        bus.d_we_i  = we;
        bus.d_ble_i = ble;
        bus.d_add_i = a;
        bus.d_d_i   = wd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.d_valid_o) begin
                got = 1'b1;
                rd = bus.d_d_o;
                break;
            end
        end
        chk(tag, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    logic [31:0] rd;
    logic [1:0]  first_g;
    logic [1:0]  second_g;
    logic        seen;

    // Random-phase requester and model state
    logic        i_busy, d_busy, d_wr, last_d, have_exp, stuck;
    logic [9:0]  i_a, d_a;
    logic [3:0]  d_b;
    logic [31:0] d_w;
    logic [1:0]  g, exp_g;
    int          i_age, d_age, ncomp, lat_max, op;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        ws = 0;
        rst = 1'b1;
        idle_bus();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re_o), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_ble", 32'(bus.mem_ble_o), 32'd0);
        chk("rst_ivalid", 32'(bus.i_valid_o), 32'd0);
        chk("rst_dvalid", 32'(bus.d_valid_o), 32'd0);
        chk("rst_id", bus.i_d_o, 32'd0);
        chk("rst_dd", bus.d_d_o, 32'd0);
        @(posedge clk);
        #1;

        // WS=0 instruction read
        d_access("t1_pre", 1'b0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, rd);
        bus.i_re_i = 1'b1;
        bus.i_add_i = 10'h010;
        @(negedge clk);
        chk("t1_idle_grant", 32'(bus.grant_o), 32'd0);
        chk("t1_idle_re", 32'(bus.mem_re_o), 32'd0);
        @(negedge clk);
        chk("t1_grant", 32'(bus.grant_o), 32'd1);
        chk("t1_mem_re", 32'(bus.mem_re_o), 32'd1);
        chk("t1_ble", 32'(bus.mem_ble_o), 32'hF);
        chk("t1_add", 32'(bus.mem_add_o), 32'h010);
        chk("t1_ivalid", 32'(bus.i_valid_o), 32'd1);
        chk("t1_idata", bus.i_d_o, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        chk("t1_back_idle", 32'(bus.grant_o), 32'd0);
        @(posedge clk);
        #1;

        // WS=2 byte-lane write, then read back
        d_access("t2_pre", 1'b0, 1'b1, 4'hF, 10'h020, 32'hAAAAAAAA, rd);
        ws = 2;
        bus.d_we_i = 1'b1;
        bus.d_ble_i = 4'b0011;
        bus.d_add_i = 10'h020;
        bus.d_d_i = 32'h12345678;
        @(negedge clk);
        chk("t2_idle", 32'(bus.grant_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_grant", 32'(bus.grant_o), 32'd2);
            chk("t2_dvalid", 32'(bus.d_valid_o), 32'(k == 2));
        end
        chk("t2_we", 32'(bus.mem_we_o), 32'd1);
        chk("t2_ble", 32'(bus.mem_ble_o), 32'h3);
        @(posedge clk);
        #1;
        idle_bus();
        d_access("t2_rd", 1'b1, 1'b0, 4'hF, 10'h020, 32'h0, rd);
        chk("t2_rdata", rd, 32'hAAAA5678);

        // Both data strobes: write wins
        ws = 0;
        bus.d_re_i = 1'b1;
        bus.d_we_i = 1'b1;
        bus.d_ble_i = 4'hF;
        bus.d_add_i = 10'h030;
        bus.d_d_i = 32'h0BADF00D;
        @(negedge clk);
        @(negedge clk);
        chk("t3_we", 32'(bus.mem_we_o), 32'd1);
        chk("t3_re", 32'(bus.mem_re_o), 32'd0);
        chk("t3_memd", bus.mem_d_o, 32'h0BADF00D);
        chk("t3_dd", bus.d_d_o, 32'h0);
        @(posedge clk);
        #1;
        idle_bus();
        d_access("t3_rd", 1'b1, 1'b0, 4'hF, 10'h030, 32'h0, rd);
        chk("t3_rdata", rd, 32'h0BADF00D);

        // Reset in the second wait cycle of a WS=3 data read
        ws = 3;
        bus.d_re_i = 1'b1;
        bus.d_add_i = 10'h030;
        @(negedge clk);
        @(negedge clk);
        chk("t4_grant", 32'(bus.grant_o), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_dvalid_rst", 32'(bus.d_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bus();
        @(negedge clk);
        chk("t4_grant_idle", 32'(bus.grant_o), 32'd0);
        chk("t4_re", 32'(bus.mem_re_o), 32'd0);
        chk("t4_we", 32'(bus.mem_we_o), 32'd0);
        chk("t4_dd", bus.d_d_o, 32'h0);
        seen = bus.d_valid_o;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | bus.d_valid_o;
        end
        chk("t4_no_dvalid", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Granted instruction port drops its request, WS=3
        bus.i_re_i = 1'b1;
        bus.i_add_i = 10'h050;
        @(negedge clk);
        @(negedge clk);
        chk("t5_grant", 32'(bus.grant_o), 32'd1);
        @(posedge clk);
        #1;
        bus.i_re_i = 1'b0;
        @(negedge clk);
        chk("t5_ivalid", 32'(bus.i_valid_o), 32'd0);
        @(negedge clk);
        chk("t5_grant_idle", 32'(bus.grant_o), 32'd0);
        chk("t5_re", 32'(bus.mem_re_o), 32'd0);
        chk("t5_ivalid2", 32'(bus.i_valid_o), 32'd0);
        @(negedge clk);
        chk("t5_mcnt", 32'(mcnt), 32'd0);
        @(posedge clk);
        #1;

        // Both ports requesting continuously, WS=1
        ws = 1;
        do_reset();
`ifdef MEM_ARB_RR_EN
        first_g = 2'b01;
        second_g = 2'b10;
`else
        first_g = 2'b10;
        second_g = 2'b01;
`endif
        bus.i_re_i = 1'b1;
        bus.i_add_i = 10'h005;
        bus.d_re_i = 1'b1;
        bus.d_add_i = 10'h006;
        @(negedge clk);
        chk("t6_idle", 32'(bus.grant_o), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_seq", 32'(bus.grant_o),
                32'(((k / 2) % 2 == 0) ? first_g : second_g));
        end
        @(posedge clk);
        #1;
        idle_bus();

        // Random two-requester traffic
        ws = $urandom_range(0, 3);
        lat_max = 2 * ws + 2;
        do_reset();
        for (int k = 0; k < 1024; k++) shadow[k] = init_word(k);
        i_busy = 0; d_busy = 0; d_wr = 0; last_d = 1;
        have_exp = 0; stuck = 0;
        i_a = '0; d_a = '0; d_b = '0; d_w = '0;
        i_age = 0; d_age = 0; ncomp = 0;
        for (int c = 0; c < 1500 && !stuck; c++) begin
            @(negedge clk);
            g = bus.grant_o;
            if (have_exp) chk("rnd_grant", 32'(g), 32'(exp_g));
            if (g == 2'b00) begin
                if (i_busy && d_busy) begin
`ifdef MEM_ARB_RR_EN
                    exp_g = last_d ? 2'b01 : 2'b10;
`else
                    exp_g = 2'b10;
`endif
                end else if (i_busy) exp_g = 2'b01;
                else if (d_busy) exp_g = 2'b10;
                else exp_g = 2'b00;
            end else if (g == 2'b01) begin
                exp_g = bus.i_valid_o ? (d_busy ? 2'b10 : 2'b00) : 2'b01;
            end else begin
                exp_g = bus.d_valid_o ? (i_busy ? 2'b01 : 2'b00) : 2'b10;
            end
            have_exp = 1;
            if (bus.i_valid_o) begin
                chk("rnd_idata", bus.i_d_o, shadow[i_a]);
                chk("rnd_ilat", 32'(i_age <= lat_max), 32'd1);
                i_busy = 0;
                last_d = 0;
                ncomp++;
            end
            if (bus.d_valid_o) begin
                if (d_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (d_b[b]) shadow[d_a][8*b +: 8] = d_w[8*b +: 8];
                end else begin
                    chk("rnd_ddata", bus.d_d_o, shadow[d_a]);
                end
                chk("rnd_dlat", 32'(d_age <= lat_max), 32'd1);
                d_busy = 0;
                last_d = 1;
                ncomp++;
            end
            if (i_busy) i_age++;
            if (d_busy) d_age++;
            if (i_age > lat_max + 4 || d_age > lat_max + 4) begin
                chk("rnd_timeout", 32'd1, 32'd0);
                stuck = 1;
            end
            if (c < 1400 && !i_busy && $urandom_range(0, 3) != 0) begin
                i_busy = 1;
                i_age = 0;
                i_a = 10'($urandom_range(0, 15));
            end
            if (c < 1400 && !d_busy && $urandom_range(0, 3) != 0) begin
                d_busy = 1;
                d_age = 0;
                op = $urandom_range(0, 2);
                d_wr = (op != 0);
                d_a = 10'($urandom_range(0, 15));
                d_b = 4'($urandom_range(0, 15));
                d_w = $urandom;
            end
            @(posedge clk);
            #1;
            bus.i_re_i = i_busy;
            bus.i_add_i = i_a;
            bus.d_re_i = d_busy && (op != 1);
            bus.d_we_i = d_busy && d_wr;
            bus.d_ble_i = d_b;
            bus.d_add_i = d_a;
            bus.d_d_i = d_w;
        end
        chk("rnd_drained", 32'(i_busy | d_busy), 32'd0);
        chk("rnd_progress", 32'(ncomp > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
